// File: rtl/gg_deblock_writeback.sv
// Deblock write-back buffer: tags up to four filtered 4x4 blocks per cycle with plane and
// linear block address, queues them, and drains one per cycle to the frame store.
module gg_deblock_writeback #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                mb_width,
  input  logic [7:0]                mbx,
  input  logic [7:0]                mby,
  input  logic [2:0]                cidx,
  input  logic [3:0]                bidx,
  input  logic                      ale_valid,
  input  logic                      abv_valid,
  input  logic                      lef_valid,
  input  logic                      cur_valid,
  input  logic [0:15][7:0]          ale_filt,
  input  logic [0:15][7:0]          abv_filt,
  input  logic [0:15][7:0]          lef_filt,
  input  logic [0:15][7:0]          cur_filt,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [1:0]                wr_plane,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [0:15][7:0]          wr_data,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      overflow,
  output logic                      idle
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef logic [ADDR_W-1:0] addr_t;

  // Storage and pointers
  logic [1:0]       mem_plane [DEPTH];
  addr_t            mem_addr  [DEPTH];
  logic [0:15][7:0] mem_data  [DEPTH];

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            overflow_q, overflow_d;

  // Plane decode
  logic       cidx_ok;
  logic       luma;
  logic [1:0] plane;

  always_comb begin
    cidx_ok = 1'b1;
    plane   = 2'd0;
    case (cidx)
      3'd0:    plane = 2'd0;
      3'd2:    plane = 2'd1;
      3'd3:    plane = 2'd2;
      default: cidx_ok = 1'b0;
    endcase
  end

  assign luma = (cidx == 3'd0);

  // Block coordinates of the current block and the row pitch in blocks
  logic [8:0]  mbw_p1;
  logic [9:0]  bx;
  logic [9:0]  by;
  logic [10:0] row_blocks;

  always_comb begin
    mbw_p1 = {1'b0, mb_width} + 9'd1;
    if (luma) begin
      bx         = {mbx, 2'b00} + {8'd0, bidx[2], bidx[0]};
      by         = {mby, 2'b00} + {8'd0, bidx[3], bidx[1]};
      row_blocks = {mbw_p1, 2'b00};
    end else begin
      bx         = {1'b0, mbx, 1'b0} + {9'd0, bidx[0]};
      by         = {1'b0, mby, 1'b0} + {9'd0, bidx[1]};
      row_blocks = {1'b0, mbw_p1, 1'b0};
    end
  end

  // Neighbour addresses derive from the current one: one row up is -row_blocks, one left is -1.
  addr_t cur_addr;
  addr_t pitch;
  addr_t slot_addr [4];
  logic [0:15][7:0] slot_data [4];
  logic [3:0] slot_stb;

  always_comb begin
    pitch        = addr_t'(row_blocks);
    cur_addr     = addr_t'(by) * pitch + addr_t'(bx);
    slot_addr[0] = cur_addr - pitch - addr_t'(1);
    slot_addr[1] = cur_addr - pitch;
    slot_addr[2] = cur_addr - addr_t'(1);
    slot_addr[3] = cur_addr;
    slot_data[0] = ale_filt;
    slot_data[1] = abv_filt;
    slot_data[2] = lef_filt;
    slot_data[3] = cur_filt;
    slot_stb     = {cur_valid, lef_valid, abv_valid, ale_valid} & {4{cidx_ok}};
  end

  // Push allocation: strobed slots take consecutive entries in ale..cur order until the
  // pre-pop free space runs out; anything later is dropped.
  logic [LvlW-1:0] free_cnt;
  logic [3:0]      slot_wr;
  logic [PtrW-1:0] slot_ptr [4];
  logic [2:0]      n_push;
  logic            drop;
  logic            pop;

  always_comb begin
    free_cnt = LvlW'(DEPTH) - level_q;
    n_push   = 3'd0;
    drop     = 1'b0;
    slot_wr  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      slot_ptr[i] = wptr_q + PtrW'(n_push);
      if (slot_stb[i]) begin
        if (LvlW'(n_push) < free_cnt) begin
          slot_wr[i] = 1'b1;
          n_push     = n_push + 3'd1;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  assign wr_valid = (level_q != '0);
  assign pop      = wr_valid & wr_ready;

  always_comb begin
    wptr_d     = wptr_q + PtrW'(n_push);
    rptr_d     = rptr_q + PtrW'(pop);
    level_d    = level_q + LvlW'(n_push) - LvlW'(pop);
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage needs no reset; only occupied entries are ever presented.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (slot_wr[i]) begin
        mem_plane[slot_ptr[i]] <= plane;
        mem_addr[slot_ptr[i]]  <= slot_addr[i];
        mem_data[slot_ptr[i]]  <= slot_data[i];
      end
    end
  end

  assign wr_plane   = mem_plane[rptr_q];
  assign wr_addr    = mem_addr[rptr_q];
  assign wr_data    = mem_data[rptr_q];
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign idle       = (level_q == '0) & ~(ale_valid | abv_valid | lef_valid | cur_valid);

endmodule

// File: tb/tb_gg_deblock_writeback.sv
// Bench for gg_deblock_writeback: directed vector table, hand sequences for fill/overflow/
// reset, and randomized traffic against a queue-based reference model.
module tb_gg_deblock_writeback;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 20;

  logic             clk;
  logic             reset;
  logic [7:0]       mb_width, mbx, mby;
  logic [2:0]       cidx;
  logic [3:0]       bidx;
  logic             ale_valid, abv_valid, lef_valid, cur_valid;
  logic [0:15][7:0] ale_filt, abv_filt, lef_filt, cur_filt;
  logic             wr_valid, wr_ready;
  logic [1:0]       wr_plane;
  logic [ADDR_W-1:0] wr_addr;
  logic [0:15][7:0] wr_data;
  logic [4:0]       fifo_level;
  logic             overflow, idle;

  gg_deblock_writeback #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .mb_width(mb_width), .mbx(mbx), .mby(mby),
    .cidx(cidx), .bidx(bidx),
    .ale_valid(ale_valid), .abv_valid(abv_valid), .lef_valid(lef_valid),
    .cur_valid(cur_valid),
    .ale_filt(ale_filt), .abv_filt(abv_filt), .lef_filt(lef_filt), .cur_filt(cur_filt),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_plane(wr_plane), .wr_addr(wr_addr),
    .wr_data(wr_data), .fifo_level(fifo_level), .overflow(overflow), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   plane;
    logic [19:0]  addr;
    logic [127:0] data;
  } ent_t;

  ent_t mq[$];
  bit   m_ovf;
  int   checks;
  int   failures;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mkblk(input int seed);
    logic [127:0] r;
    for (int p = 0; p < 16; p++) r[127-8*p -: 8] = 8'(seed * 37 + p * 11 + 5);
    return r;
  endfunction

  function automatic void geom(input int mbw, input int mx, input int my, input int c,
                               input logic [3:0] b, output int bx, output int by,
                               output int rb);
    if (c == 0) begin
      bx = mx * 4 + 2 * int'(b[2]) + int'(b[0]);
      by = my * 4 + 2 * int'(b[3]) + int'(b[1]);
      rb = (mbw + 1) * 4;
    end else begin
      bx = mx * 2 + int'(b[0]);
      by = my * 2 + int'(b[1]);
      rb = (mbw + 1) * 2;
    end
  endfunction

  task automatic set_in(input int mbw, input int mx, input int my, input int c, input int b,
                        input logic [3:0] stb, input int seed);
    mb_width = 8'(mbw);
    mbx      = 8'(mx);
    mby      = 8'(my);
    cidx     = 3'(c);
    bidx     = 4'(b);
    {cur_valid, lef_valid, abv_valid, ale_valid} = stb;
    ale_filt = mkblk(seed);
    abv_filt = mkblk(seed + 1);
    lef_filt = mkblk(seed + 2);
    cur_filt = mkblk(seed + 3);
  endtask

  task automatic clr();
    {cur_valid, lef_valid, abv_valid, ale_valid} = 4'b0000;
  endtask

  // Check outputs against the model, then advance the model and the DUT by one clock.
  task automatic tick();
    logic [3:0] stb;
    int dxs[4] = '{-1, 0, -1, 0};
    int dys[4] = '{-1, -1, 0, 0};
    int bx, by, rb, free_n, n, pl;
    bit pop;
    ent_t e;
    #1;
    stb = {cur_valid, lef_valid, abv_valid, ale_valid};
    chk("wr_valid", 128'(wr_valid), 128'(mq.size() != 0));
    chk("fifo_level", 128'(fifo_level), 128'(mq.size()));
    chk("overflow", 128'(overflow), 128'(m_ovf));
    chk("idle", 128'(idle), 128'(mq.size() == 0 && stb == 4'b0000));
    if (mq.size() != 0) begin
      chk("wr_plane", 128'(wr_plane), 128'(mq[0].plane));
      chk("wr_addr", 128'(wr_addr), 128'(mq[0].addr));
      chk("wr_data", wr_data, mq[0].data);
    end
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      pop = (mq.size() != 0) && wr_ready;
      pl  = (cidx == 0) ? 0 : (cidx == 2) ? 1 : (cidx == 3) ? 2 : -1;
      if (pl >= 0) begin
        geom(int'(mb_width), int'(mbx), int'(mby), int'(cidx), bidx, bx, by, rb);
        free_n = DEPTH - mq.size();
        n = 0;
        for (int s = 0; s < 4; s++) begin
          if (stb[s]) begin
            if (n < free_n) begin
              e.plane = 2'(pl);
              e.addr  = 20'(((by + dys[s]) * rb + bx + dxs[s]) & ((1 << ADDR_W) - 1));
              e.data  = (s == 0) ? ale_filt : (s == 1) ? abv_filt :
                        (s == 2) ? lef_filt : cur_filt;
              mq.push_back(e);
              n++;
            end else begin
              m_ovf = 1'b1;
            end
          end
        end
      end
      if (pop) void'(mq.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    int mbw, mx, my, c, b;
    logic [3:0] stb;
    int n;
    logic [1:0] plane;
    logic [3:0][19:0] addr;
  } vec_t;

  vec_t vt[5];

  initial begin
    int bx, by, rb, k, seed;
    logic [3:0] stb;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    wr_ready = 1'b0;
    set_in(0, 0, 0, 0, 0, 4'b0000, 0);
    repeat (2) @(negedge clk);
    mq.delete();
    m_ovf = 1'b0;
    reset = 1'b0;
    #1;
    chk("reset_wr_valid", 128'(wr_valid), 128'(0));
    chk("reset_level", 128'(fifo_level), 128'(0));
    chk("reset_overflow", 128'(overflow), 128'(0));
    chk("reset_idle", 128'(idle), 128'(1));
    @(negedge clk);

    // Directed vectors: stb bit 0=ale, 1=abv, 2=lef, 3=cur; addr[k] is the k-th pop.
    vt[0] = '{2, 1, 0, 0, 5, 4'b1000, 1, 2'd0, {20'd0, 20'd0, 20'd0, 20'd7}};
    vt[1] = '{2, 1, 1, 0, 0, 4'b1111, 4, 2'd0, {20'd52, 20'd51, 20'd40, 20'd39}};
    vt[2] = '{2, 2, 1, 3, 3, 4'b1100, 2, 2'd2, {20'd0, 20'd0, 20'd23, 20'd22}};
    vt[3] = '{0, 0, 0, 2, 0, 4'b1000, 1, 2'd1, {20'd0, 20'd0, 20'd0, 20'd0}};
    vt[4] = '{2, 1, 1, 1, 0, 4'b1111, 0, 2'd0, {20'd0, 20'd0, 20'd0, 20'd0}};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      wr_ready = 1'b1;
      seed = 10 * i + 3;
      set_in(vt[i].mbw, vt[i].mx, vt[i].my, vt[i].c, vt[i].b, vt[i].stb, seed);
      tick();
      clr();
      k = 0;
      for (int s = 0; s < 4; s++) begin
        if (vt[i].stb[s] && k < vt[i].n) begin
          #1;
          chk($sformatf("vec%0d_valid%0d", i, k), 128'(wr_valid), 128'(1));
          chk($sformatf("vec%0d_addr%0d", i, k), 128'(wr_addr), 128'(vt[i].addr[k]));
          chk($sformatf("vec%0d_plane%0d", i, k), 128'(wr_plane), 128'(vt[i].plane));
          chk($sformatf("vec%0d_data%0d", i, k), wr_data, mkblk(seed + s));
          tick();
          k++;
        end
      end
      #1;
      chk($sformatf("vec%0d_drained", i), 128'(wr_valid), 128'(0));
      chk($sformatf("vec%0d_no_ovf", i), 128'(overflow), 128'(0));
    end

    // Fill with the sink stalled, then one extra burst that must be dropped.
    do_reset();
    wr_ready = 1'b0;
    for (int b = 0; b < 5; b++) begin
      set_in(2, 1, 1, 0, 0, 4'b1111, 100 + 4 * b);
      tick();
    end
    clr();
    #1;
    chk("full_level", 128'(fifo_level), 128'(16));
    chk("full_overflow", 128'(overflow), 128'(1));
    wr_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      #1;
      chk($sformatf("full_data%0d", j), wr_data, mkblk(100 + j));
      tick();
    end
    #1;
    chk("full_drained", 128'(wr_valid), 128'(0));

    // Push and pop in the same cycle at level 15 and at level 16.
    do_reset();
    wr_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      set_in(2, 1, 1, 0, 0, (b == 3) ? 4'b0111 : 4'b1111, 200 + 4 * b);
      tick();
    end
    #1;
    chk("l15_level_pre", 128'(fifo_level), 128'(15));
    wr_ready = 1'b1;
    set_in(2, 1, 1, 0, 0, 4'b1000, 300);
    tick();
    #1;
    chk("l15_level", 128'(fifo_level), 128'(15));
    chk("l15_overflow", 128'(overflow), 128'(0));
    wr_ready = 1'b0;
    tick();
    #1;
    chk("l16_level_pre", 128'(fifo_level), 128'(16));
    wr_ready = 1'b1;
    tick();
    clr();
    #1;
    chk("l16_level", 128'(fifo_level), 128'(15));
    chk("l16_overflow", 128'(overflow), 128'(1));

    // Reset with queued blocks, then a clean restart.
    do_reset();
    wr_ready = 1'b0;
    set_in(2, 1, 1, 0, 0, 4'b1111, 400);
    tick();
    set_in(2, 1, 1, 0, 0, 4'b0111, 404);
    tick();
    #1;
    chk("rst_level_pre", 128'(fifo_level), 128'(7));
    do_reset();
    #1;
    chk("rst_valid", 128'(wr_valid), 128'(0));
    chk("rst_level", 128'(fifo_level), 128'(0));
    chk("rst_overflow", 128'(overflow), 128'(0));
    set_in(2, 1, 0, 0, 5, 4'b1000, 500);
    tick();
    clr();
    #1;
    chk("rst_restart_valid", 128'(wr_valid), 128'(1));
    chk("rst_restart_addr", 128'(wr_addr), 128'(7));
    chk("rst_restart_data", wr_data, mkblk(503));

    // Randomized traffic against the model.
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      int c, mw, mx, my, b;
      wr_ready = ($urandom_range(0, 99) < 60);
      c  = $urandom_range(0, 4);
      if (c == 4) c = 0;
      mw = $urandom_range(0, 255);
      mx = $urandom_range(0, 255);
      my = $urandom_range(0, 255);
      b  = $urandom_range(0, 15);
      stb = 4'($urandom_range(0, 15));
      geom(mw, mx, my, c, 4'(b), bx, by, rb);
      if (bx == 0) begin
        stb[0] = 1'b0;
        stb[2] = 1'b0;
      end
      if (by == 0) begin
        stb[0] = 1'b0;
        stb[1] = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) stb = 4'b0000;
      set_in(mw, mx, my, c, b, stb, int'($urandom));
      reset = ($urandom_range(0, 199) == 0);
      tick();
      reset = 1'b0;
    end
    clr();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
